mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 64-bit data-memory port between instruction fetch (IF, read-only)
//  and the load/store unit (LS, read/write with byte mask).
//  Sits between the pipeline stages and the memory/bus side.
//  One transaction is outstanding at a time; requests use valid/ready, responses use a valid pulse.
//  Round-robin arbitration prevents starvation of either requester.
// PARAMETERS
//  ADDR_W   64  request address width
//  DATA_W   64  read/write data width
//  MASK_W   8   byte write-mask width (DATA_W/8)
// PORTS
//  clk            input   1       clock, all state on posedge
//  rst            input   1       synchronous reset, active-low (0 = reset)
//  if_req_valid   input   1       IF read request
//  if_req_ready   output  1       IF request accepted this cycle
//  if_req_addr    input   ADDR_W  IF read address
//  if_resp_valid  output  1       IF read data valid (1-cycle pulse)
//  if_resp_rdata  output  DATA_W  IF read data
//  ls_req_valid   input   1       LS request
//  ls_req_ready   output  1       LS request accepted this cycle
//  ls_req_addr    input   ADDR_W  LS address
//  ls_req_wen     input   1       1 = store, 0 = load
//  ls_req_wdata   input   DATA_W  store data, already lane-replicated
//  ls_req_wmask   input   MASK_W  store byte mask
//  ls_resp_valid  output  1       LS load data / store ack (1-cycle pulse)
//  ls_resp_rdata  output  DATA_W  LS load data, raw 8-byte-aligned doubleword
//  mem_req_valid  output  1       request to memory
//  mem_req_ready  input   1       memory accepts request
//  mem_req_addr   output  ADDR_W  latched address
//  mem_req_wen    output  1       latched write enable
//  mem_req_wdata  output  DATA_W  latched write data
//  mem_req_wmask  output  MASK_W  latched mask, forced to 0 when wen=0
//  mem_resp_valid input   1       memory response (read data or write ack)
//  mem_resp_rdata input   DATA_W  memory read data
// BEHAVIOUR
//  FSM states: IDLE, ISSUE, WAIT. Registers: owner (IF/LS), last_grant (IF/LS), latched request fields.
//  Reset (rst=0 at posedge): state=IDLE, last_grant=IF, and all latched fields cleared to 0.
//    Every output is then 0.
//  IDLE arbitration (combinational):
//    - only one requester valid -> grant it.
//    - both valid -> grant the one != last_grant.
//  In IDLE, x_req_ready=1 for the granted requester only. Both readies are 0 in ISSUE and WAIT.
//  Accept (valid&&ready) at cycle T:
//    - latch addr/wen/wdata/wmask. IF requests latch wen=0 and wmask=0.
//    - set owner and last_grant; enter ISSUE at T+1.
//  ISSUE: mem_req_valid=1. Addr, wen, wdata and wmask stay stable until mem_req_ready=1,
//    then go to WAIT on the next cycle.
//  WAIT: on mem_resp_valid=1, return to IDLE on the next cycle.
//    - owner_resp_valid = mem_resp_valid, combinationally, in the same cycle.
//    - owner_resp_rdata = mem_resp_rdata; the other resp_valid stays 0.
//    - resp_rdata is 0 whenever its resp_valid is 0.
//  Minimum turnaround: accept T, mem_req T+1 (ready=1), resp T+2, next accept T+3.
//  mem_resp_valid outside WAIT is ignored. A response in the same cycle as mem_req_ready is ignored.
//  Stores complete only on their ack: LS must not see ls_resp_valid before memory acknowledges.
//  Requester valid may drop before acceptance; nothing is latched then and last_grant is unchanged.
//  ls_req_wen=1 with wmask=0 is forwarded unchanged (no-op write still waits for ack).
//  Reset mid-transaction: FSM returns to IDLE and the in-flight transaction is dropped with no
//    resp pulse. The memory side is reset by the same rst.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with both reqs valid -> all outputs 0; after release, LS granted first.
//  2 IF only: addr=0x8000_0000, mem_ready=1 at T+1, resp=0x1122334455667788 at T+3
//    -> if_resp_valid pulse at T+3 with that data; mem_req_wen=0, wmask=0.
//  3 Contention: both valid continuously for 4 transactions -> grants alternate LS, IF, LS, IF.
//  4 Store: addr=0x8000_0008, wdata=0xAAAA..AA, wmask=0x0F, mem_req_ready held 0 for 3 cycles
//    -> fields stable, no new grant; ls_resp_valid only on the ack.
//  5 Spurious mem_resp_valid in IDLE and ISSUE -> no resp pulse on either requester.
//  6 rst=0 during WAIT -> IDLE, no resp pulse; next IF request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, LS) and memory-side handshake signals around mem_port_arbiter.
// slave: the arbiter's view; master: the pipeline/memory environment driving it.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned MASK_W = 8
);
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_resp_valid;
   logic [DATA_W-1:0] if_resp_rdata;

   logic              ls_req_valid;
   logic              ls_req_ready;
   logic [ADDR_W-1:0] ls_req_addr;
   logic              ls_req_wen;
   logic [DATA_W-1:0] ls_req_wdata;
   logic [MASK_W-1:0] ls_req_wmask;
   logic              ls_resp_valid;
   logic [DATA_W-1:0] ls_resp_rdata;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_wen;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [MASK_W-1:0] mem_req_wmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_rdata;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_resp_valid, if_resp_rdata,
      input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
      output ls_req_ready, ls_resp_valid, ls_resp_rdata,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_resp_valid, if_resp_rdata,
      output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
      input  ls_req_ready, ls_resp_valid, ls_resp_rdata,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight: IDLE (arbitrate) -> ISSUE (hold request) -> WAIT (route response).
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned MASK_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   typedef enum logic {REQ_IF, REQ_LS} req_t;

   state_t            state;
   req_t              owner;
   req_t              last_grant;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] wmask_q;

   logic grant_if;
   logic grant_ls;
   logic accept_if;
   logic accept_ls;
   logic resp_fire;

   // On contention, the requester not served last wins
   always_comb begin
      grant_if  = 1'b0;
      grant_ls  = 1'b0;
      if (bus.if_req_valid && bus.ls_req_valid) begin
         grant_ls = (last_grant == REQ_IF);
         grant_if = (last_grant == REQ_LS);
      end else begin
         grant_if = bus.if_req_valid;
         grant_ls = bus.ls_req_valid;
      end
      accept_if = rst && (state == IDLE) && grant_if;
      accept_ls = rst && (state == IDLE) && grant_ls;
      resp_fire = rst && (state == WAIT) && bus.mem_resp_valid;
   end

   // Readies and responses are combinational and masked while reset is asserted
   always_comb begin
      bus.if_req_ready  = accept_if;
      bus.ls_req_ready  = accept_ls;
      bus.if_resp_valid = resp_fire && (owner == REQ_IF);
      bus.ls_resp_valid = resp_fire && (owner == REQ_LS);
      bus.if_resp_rdata = bus.if_resp_valid ? bus.mem_resp_rdata : DATA_W'(0);
      bus.ls_resp_rdata = bus.ls_resp_valid ? bus.mem_resp_rdata : DATA_W'(0);
      bus.mem_req_valid = (state == ISSUE);
      bus.mem_req_addr  = addr_q;
      bus.mem_req_wen   = wen_q;
      bus.mem_req_wdata = wdata_q;
      bus.mem_req_wmask = wmask_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= REQ_IF;
         last_grant <= REQ_IF;
         addr_q     <= ADDR_W'(0);
         wen_q      <= 1'b0;
         wdata_q    <= DATA_W'(0);
         wmask_q    <= MASK_W'(0);
      end else begin
         case (state)
            IDLE: begin
               if (accept_ls) begin
                  owner      <= REQ_LS;
                  last_grant <= REQ_LS;
                  addr_q     <= bus.ls_req_addr;
                  wen_q      <= bus.ls_req_wen;
                  wdata_q    <= bus.ls_req_wdata;
                  wmask_q    <= bus.ls_req_wen ? bus.ls_req_wmask : MASK_W'(0);
                  state      <= ISSUE;
               end else if (accept_if) begin
                  owner      <= REQ_IF;
                  last_grant <= REQ_IF;
                  addr_q     <= bus.if_req_addr;
                  wen_q      <= 1'b0;
                  wdata_q    <= DATA_W'(0);
                  wmask_q    <= MASK_W'(0);
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.mem_req_ready) state <= WAIT;
            end
            WAIT: begin
               if (bus.mem_resp_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter plus a bounded hand-written store sequence.
module tb_mem_port_arbiter;

   localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] DW = 64'h1122_3344_5566_7788;
   localparam int NV = 37;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ifv;
      logic [63:0] ifa;
      logic        lsv;
      logic [63:0] lsa;
      logic        lswen;
      logic [63:0] lswd;
      logic [7:0]  lswm;
      logic        mrdy;
      logic        mrv;
      logic [63:0] mrd;
      logic        e_ifr;
      logic        e_lsr;
      logic        e_mqv;
      logic [63:0] e_mqa;
      logic        e_mqwen;
      logic [63:0] e_mqwd;
      logic [7:0]  e_mqwm;
      logic        e_ifrv;
      logic [63:0] e_ifrd;
      logic        e_lsrv;
      logic [63:0] e_lsrd;
   } vec_t;

   vec_t vecs [NV];

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst                = v.rst;
      bus.if_req_valid   = v.ifv;
      bus.if_req_addr    = v.ifa;
      bus.ls_req_valid   = v.lsv;
      bus.ls_req_addr    = v.lsa;
      bus.ls_req_wen     = v.lswen;
      bus.ls_req_wdata   = v.lswd;
      bus.ls_req_wmask   = v.lswm;
      bus.mem_req_ready  = v.mrdy;
      bus.mem_resp_valid = v.mrv;
      bus.mem_resp_rdata = v.mrd;
   endtask

   task automatic check_vec(input vec_t v, input int idx);
      chk("if_req_ready",  idx, 64'(bus.if_req_ready),  64'(v.e_ifr));
      chk("ls_req_ready",  idx, 64'(bus.ls_req_ready),  64'(v.e_lsr));
      chk("mem_req_valid", idx, 64'(bus.mem_req_valid), 64'(v.e_mqv));
      chk("mem_req_addr",  idx, bus.mem_req_addr,       v.e_mqa);
      chk("mem_req_wen",   idx, 64'(bus.mem_req_wen),   64'(v.e_mqwen));
      chk("mem_req_wdata", idx, bus.mem_req_wdata,      v.e_mqwd);
      chk("mem_req_wmask", idx, 64'(bus.mem_req_wmask), 64'(v.e_mqwm));
      chk("if_resp_valid", idx, 64'(bus.if_resp_valid), 64'(v.e_ifrv));
      chk("if_resp_rdata", idx, bus.if_resp_rdata,      v.e_ifrd);
      chk("ls_resp_valid", idx, 64'(bus.ls_resp_valid), 64'(v.e_lsrv));
      chk("ls_resp_rdata", idx, bus.ls_resp_rdata,      v.e_lsrd);
   endtask

   initial begin
      vec_t idle_v;
      bit   seen;
      n_checks = 0;
      n_fail   = 0;

      // rst ifv ifa lsv lsa wen wd wm mrdy mrv mrd | ifr lsr mqv mqa wen wd wm ifrv ifrd lsrv lsrd
      // Reset held with both requesters valid
      vecs[0]  = '{0,1,64'h1000,1,64'h2000,0,0,0,0,0,0,       0,0,0,64'h0,0,0,0,0,0,0,0};
      vecs[1]  = '{0,1,64'h1000,1,64'h2000,0,0,0,0,0,0,       0,0,0,64'h0,0,0,0,0,0,0,0};
      vecs[2]  = '{0,1,64'h1000,1,64'h2000,0,0,0,0,0,0,       0,0,0,64'h0,0,0,0,0,0,0,0};
      // Contention: LS, IF, LS, IF
      vecs[3]  = '{1,1,64'h1000,1,64'h2000,0,0,0,0,0,0,       0,1,0,64'h0,0,0,0,0,0,0,0};
      vecs[4]  = '{1,1,64'h1000,1,64'h2000,0,0,0,1,0,0,       0,0,1,64'h2000,0,0,0,0,0,0,0};
      vecs[5]  = '{1,1,64'h1000,1,64'h2000,0,0,0,0,1,64'h55,  0,0,0,64'h2000,0,0,0,0,0,1,64'h55};
      vecs[6]  = '{1,1,64'h1000,1,64'h2000,0,0,0,0,0,0,       1,0,0,64'h2000,0,0,0,0,0,0,0};
      vecs[7]  = '{1,1,64'h1000,1,64'h2000,0,0,0,1,0,0,       0,0,1,64'h1000,0,0,0,0,0,0,0};
      vecs[8]  = '{1,1,64'h1000,1,64'h2000,0,0,0,0,1,64'h66,  0,0,0,64'h1000,0,0,0,1,64'h66,0,0};
      vecs[9]  = '{1,1,64'h1000,1,64'h2000,0,0,0,0,0,0,       0,1,0,64'h1000,0,0,0,0,0,0,0};
      vecs[10] = '{1,1,64'h1000,1,64'h2000,0,0,0,1,0,0,       0,0,1,64'h2000,0,0,0,0,0,0,0};
      vecs[11] = '{1,1,64'h1000,1,64'h2000,0,0,0,0,1,64'h77,  0,0,0,64'h2000,0,0,0,0,0,1,64'h77};
      vecs[12] = '{1,1,64'h1000,1,64'h2000,0,0,0,0,0,0,       1,0,0,64'h2000,0,0,0,0,0,0,0};
      vecs[13] = '{1,0,64'h0,0,64'h0,0,0,0,1,0,0,             0,0,1,64'h1000,0,0,0,0,0,0,0};
      vecs[14] = '{1,0,64'h0,0,64'h0,0,0,0,0,1,64'h88,        0,0,0,64'h1000,0,0,0,1,64'h88,0,0};
      // IF only, response one cycle late
      vecs[15] = '{1,1,64'h8000_0000,0,64'h0,0,0,0,0,0,0,     1,0,0,64'h1000,0,0,0,0,0,0,0};
      vecs[16] = '{1,0,64'h0,0,64'h0,0,0,0,1,0,0,             0,0,1,64'h8000_0000,0,0,0,0,0,0,0};
      vecs[17] = '{1,0,64'h0,0,64'h0,0,0,0,0,0,0,             0,0,0,64'h8000_0000,0,0,0,0,0,0,0};
      vecs[18] = '{1,0,64'h0,0,64'h0,0,0,0,0,1,DW,            0,0,0,64'h8000_0000,0,0,0,1,DW,0,0};
      // Store with memory stalling 3 cycles while IF keeps requesting
      vecs[19] = '{1,1,64'h3000,1,64'h8000_0008,1,AA,8'h0F,0,0,0, 0,1,0,64'h8000_0000,0,0,0,0,0,0,0};
      vecs[20] = '{1,1,64'h3000,0,64'h0,0,0,0,0,0,0,          0,0,1,64'h8000_0008,1,AA,8'h0F,0,0,0,0};
      vecs[21] = '{1,1,64'h3000,0,64'h0,0,0,0,0,0,0,          0,0,1,64'h8000_0008,1,AA,8'h0F,0,0,0,0};
      vecs[22] = '{1,1,64'h3000,0,64'h0,0,0,0,0,0,0,          0,0,1,64'h8000_0008,1,AA,8'h0F,0,0,0,0};
      vecs[23] = '{1,1,64'h3000,0,64'h0,0,0,0,1,0,0,          0,0,1,64'h8000_0008,1,AA,8'h0F,0,0,0,0};
      vecs[24] = '{1,1,64'h3000,0,64'h0,0,0,0,0,0,0,          0,0,0,64'h8000_0008,1,AA,8'h0F,0,0,0,0};
      vecs[25] = '{1,1,64'h3000,0,64'h0,0,0,0,0,1,64'h1234,   0,0,0,64'h8000_0008,1,AA,8'h0F,0,0,1,64'h1234};
      // Spurious responses in IDLE and ISSUE (including same cycle as ready)
      vecs[26] = '{1,0,64'h0,0,64'h0,0,0,0,0,1,64'hBAD,       0,0,0,64'h8000_0008,1,AA,8'h0F,0,0,0,0};
      vecs[27] = '{1,1,64'h40,0,64'h0,0,0,0,0,1,64'hBAD,      1,0,0,64'h8000_0008,1,AA,8'h0F,0,0,0,0};
      vecs[28] = '{1,0,64'h0,0,64'h0,0,0,0,1,1,64'hBAD,       0,0,1,64'h40,0,0,0,0,0,0,0};
      vecs[29] = '{1,0,64'h0,0,64'h0,0,0,0,0,0,0,             0,0,0,64'h40,0,0,0,0,0,0,0};
      vecs[30] = '{1,0,64'h0,0,64'h0,0,0,0,0,1,64'h99,        0,0,0,64'h40,0,0,0,1,64'h99,0,0};
      // Reset during WAIT drops the load; next IF served normally
      vecs[31] = '{1,0,64'h0,1,64'h100,0,0,0,0,0,0,           0,1,0,64'h40,0,0,0,0,0,0,0};
      vecs[32] = '{1,0,64'h0,0,64'h0,0,0,0,1,0,0,             0,0,1,64'h100,0,0,0,0,0,0,0};
      vecs[33] = '{0,0,64'h0,0,64'h0,0,0,0,0,1,64'hEE,        0,0,0,64'h100,0,0,0,0,0,0,0};
      vecs[34] = '{1,1,64'h200,0,64'h0,0,0,0,0,0,0,           1,0,0,64'h0,0,0,0,0,0,0,0};
      vecs[35] = '{1,0,64'h0,0,64'h0,0,0,0,1,0,0,             0,0,1,64'h200,0,0,0,0,0,0,0};
      vecs[36] = '{1,0,64'h0,0,64'h0,0,0,0,0,1,64'hABC,       0,0,0,64'h200,0,0,0,1,64'hABC,0,0};

      idle_v = '{0,0,64'h0,0,64'h0,0,0,0,0,0,0, 0,0,0,64'h0,0,0,0,0,0,0,0};
      drive(idle_v);
      @(posedge clk);
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         #1;
         check_vec(vecs[i], i);
         @(posedge clk);
         #1;
      end

      // No-op store (wmask=0) is forwarded unchanged and still waits for its ack
      idle_v.rst = 1'b1;
      drive(idle_v);
      bus.ls_req_valid = 1'b1;
      bus.ls_req_addr  = 64'h300;
      bus.ls_req_wen   = 1'b1;
      bus.ls_req_wdata = 64'h5A5A;
      bus.ls_req_wmask = 8'h00;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         #1;
         if (bus.ls_req_ready) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("noop_accept", 100, 64'(seen), 64'h1);
      bus.ls_req_valid  = 1'b0;
      bus.mem_req_ready = 1'b1;
      #1;
      chk("noop_mqv",  101, 64'(bus.mem_req_valid), 64'h1);
      chk("noop_wen",  102, 64'(bus.mem_req_wen),   64'h1);
      chk("noop_mask", 103, 64'(bus.mem_req_wmask), 64'h0);
      chk("noop_addr", 104, bus.mem_req_addr,       64'h300);
      @(posedge clk);
      #1;
      bus.mem_req_ready = 1'b0;
      #1;
      chk("noop_early_ack", 105, 64'(bus.ls_resp_valid), 64'h0);
      @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 64'h0;
      #1;
      chk("noop_ack", 106, 64'(bus.ls_resp_valid), 64'h1);
      chk("noop_if_quiet", 107, 64'(bus.if_resp_valid), 64'h0);
      @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
